lap_stopwatch: RTL and testbench
================================

Name: lap_stopwatch

Overview:
- Parametrised stopwatch core with lap memory; successor to the fixed 5-lap stopwatch path in the clock top.
- Counts minutes, seconds and centiseconds from an internal prescaler.
- Captures up to LAPS lap times while running and replays them one at a time while stopped.
- Outputs feed the existing 7-segment display path as binary minute, second and centisecond values, plus status LEDs.

Parameters:
- TICK_DIV, 500000, CLK cycles per centisecond tick (500000 gives 100 Hz at 50 MHz); must be >= 1.
- LAPS, 5, number of lap slots; must be >= 1.
- MIN_MAX, 59, highest minute value before the count wraps to 0.
- IDXW, $clog2(LAPS+1), width of the lap index and lap count.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high; returns the block to its reset state.
- start_stop  in  1  one-CLK pulse, already debounced; toggles run/stop.
- lap  in  1  one-CLK pulse; captures a lap.
- recall  in  1  one-CLK pulse; enters or steps lap replay.
- clear  in  1  one-CLK pulse; zeroes the time and all laps.
- disp_min  out  7  displayed minutes.
- disp_sec  out  7  displayed seconds.
- disp_cs  out  7  displayed centiseconds.
- running  out  1  high in RUN.
- recall_mode  out  1  high in RECALL.
- recall_idx  out  IDXW  slot being shown (0-based); 0 outside RECALL.
- lap_count  out  IDXW  number of stored laps.
- laps_full  out  1  lap_count == LAPS.
- overflow  out  1  sticky; set when minutes wrap from MIN_MAX to 0.

Behaviour:
- Reset state: all internal registers, lap slots, lap_count and overflow are 0; state is IDLE. Consequently all outputs are 0.
- States: IDLE (stopped, live time shown), RUN, RECALL. All state and register updates take effect on the CLK edge that samples the pulse. Outputs are combinational from registers, so they change in the same cycle as the update.
- Prescaler: counts 0..TICK_DIV-1 and advances only in RUN; it holds its value in IDLE and RECALL. A tick is generated on the cycle the prescaler is at TICK_DIV-1, and the prescaler then returns to 0.
- Time count on each tick:
  - cs increments and wraps 99->0.
  - On a cs wrap, sec increments and wraps 59->0.
  - On a sec wrap, min increments and wraps MIN_MAX->0; that wrap sets overflow.
  - All three values are binary, never exceed their maxima, and update in a single cycle.
- IDLE transitions:
  - start_stop -> RUN.
  - recall with lap_count > 0 -> RECALL, recall_idx = 0.
  - recall with lap_count == 0 is ignored.
  - lap is ignored.
- RUN transitions and actions:
  - start_stop -> IDLE; time freezes and the prescaler holds its value.
  - lap with lap_count < LAPS: store {min,sec,cs} in slot lap_count, then lap_count increments.
  - lap with lap_count == LAPS is ignored; no overwrite.
  - recall and clear are ignored.
- RECALL transitions:
  - recall: if recall_idx < lap_count-1, recall_idx increments; otherwise -> IDLE and recall_idx = 0.
  - start_stop -> IDLE without starting; the time is unchanged.
  - lap is ignored.
- clear in IDLE or RECALL: zeroes min, sec, cs, the prescaler, all slots, lap_count and overflow; the next state is IDLE.
- Display mux: in RECALL the disp_* outputs show slot[recall_idx]; otherwise they show the live count.
- Simultaneous events:
  - clear has highest priority. In a state where clear is honoured, all other pulses in that cycle are ignored.
  - lap + start_stop in RUN: the lap is captured first (pre-stop value), then the block stops.
  - lap coinciding with a tick: the captured value is the pre-increment register value.
  - recall + start_stop in IDLE: start_stop wins (-> RUN).
  - recall + start_stop in RECALL: start_stop wins (-> IDLE).
- reset asserted mid-operation overrides every input and forces the reset state on the next edge, whatever the current state.

Test Plan:
- TICK_DIV=2. Reset, then start_stop, then run 2*100 cycles -> disp_cs=0, disp_sec=1, disp_min=0, running=1.
- TICK_DIV=1, MIN_MAX=1. Run 12000 ticks -> min wraps 1->0, overflow=1. Then stop + clear -> all zero, overflow=0.
- LAPS=2. Pulse lap at cs=5, cs=9 and cs=20 while running -> lap_count=2, laps_full=1, third lap ignored. Then stop and recall twice -> disp_cs shows 5 then 9. A third recall returns to live display, recall_mode=0.
- lap + start_stop in the same cycle at cs=37 -> stored slot 0 = 37, running=0, live disp_cs=37 held.
- recall with lap_count=0 -> stays IDLE. clear during RUN -> ignored, count continues. reset during RECALL -> all outputs 0 next cycle.
- clear + recall in the same cycle in RECALL -> IDLE, lap_count=0, time=0.

Source files
------------

// File: rtl/lap_stopwatch.sv
// Stopwatch core: min/sec/cs counter driven by a centisecond prescaler,
// with LAPS lap slots captured while running and replayed while stopped.
module lap_stopwatch #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned LAPS     = 5,
    parameter int unsigned MIN_MAX  = 59,
    parameter int unsigned IDXW     = $clog2(LAPS + 1)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start_stop,
    input  logic            lap,
    input  logic            recall,
    input  logic            clear,
    output logic [6:0]      disp_min,
    output logic [6:0]      disp_sec,
    output logic [6:0]      disp_cs,
    output logic            running,
    output logic            recall_mode,
    output logic [IDXW-1:0] recall_idx,
    output logic [IDXW-1:0] lap_count,
    output logic            laps_full,
    output logic            overflow
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StRecall} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [6:0]        min_q, min_d, sec_q, sec_d, cs_q, cs_d;
    logic [20:0]       slot_q [LAPS];
    logic [20:0]       slot_d [LAPS];
    logic [IDXW-1:0]   lap_cnt_q, lap_cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic              tick;
    logic              clr;
    logic [20:0]       shown;

    assign tick = (state_q == StRun) && (presc_q == PW'(TICK_DIV - 1));
    // clear is only honoured while stopped; it then masks every other pulse
    assign clr  = clear && (state_q != StRun);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        min_d     = min_q;
        sec_d     = sec_q;
        cs_d      = cs_q;
        slot_d    = slot_q;
        lap_cnt_d = lap_cnt_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;

        if (clr) begin
            state_d   = StIdle;
            presc_d   = '0;
            min_d     = '0;
            sec_d     = '0;
            cs_d      = '0;
            lap_cnt_d = '0;
            idx_d     = '0;
            ovf_d     = 1'b0;
            for (int i = 0; i < int'(LAPS); i++) slot_d[i] = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_stop) begin
                        state_d = StRun;
                    end else if (recall && (lap_cnt_q != '0)) begin
                        state_d = StRecall;
                        idx_d   = '0;
                    end
                end
                StRun: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (cs_q == 7'd99) begin
                            cs_d = '0;
                            if (sec_q == 7'd59) begin
                                sec_d = '0;
                                if (min_q == 7'(MIN_MAX)) begin
                                    min_d = '0;
                                    ovf_d = 1'b1;
                                end else begin
                                    min_d = min_q + 7'd1;
                                end
                            end else begin
                                sec_d = sec_q + 7'd1;
                            end
                        end else begin
                            cs_d = cs_q + 7'd1;
                        end
                    end
                    // capture uses the pre-tick register value
                    if (lap && (lap_cnt_q < IDXW'(LAPS))) begin
                        for (int i = 0; i < int'(LAPS); i++) begin
                            if (lap_cnt_q == IDXW'(i)) slot_d[i] = {min_q, sec_q, cs_q};
                        end
                        lap_cnt_d = lap_cnt_q + IDXW'(1);
                    end
                    if (start_stop) state_d = StIdle;
                end
                StRecall: begin
                    if (start_stop) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else if (recall) begin
                        if (({1'b0, idx_q} + (IDXW + 1)'(1)) < {1'b0, lap_cnt_q}) begin
                            idx_d = idx_q + IDXW'(1);
                        end else begin
                            state_d = StIdle;
                            idx_d   = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            cs_q      <= '0;
            slot_q    <= '{default: '0};
            lap_cnt_q <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            cs_q      <= cs_d;
            slot_q    <= slot_d;
            lap_cnt_q <= lap_cnt_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        shown = {min_q, sec_q, cs_q};
        if (state_q == StRecall) begin
            for (int i = 0; i < int'(LAPS); i++) begin
                if (idx_q == IDXW'(i)) shown = slot_q[i];
            end
        end
    end

    assign disp_min    = shown[20:14];
    assign disp_sec    = shown[13:7];
    assign disp_cs     = shown[6:0];
    assign running     = (state_q == StRun);
    assign recall_mode = (state_q == StRecall);
    assign recall_idx  = idx_q;
    assign lap_count   = lap_cnt_q;
    assign laps_full   = (lap_cnt_q == IDXW'(LAPS));
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: elapsed-time model (total run cycles / TICK_DIV)
// with lap queue, per-cycle comparison, directed literal checks and random pulses.
module tb_lap_stopwatch;

    localparam int unsigned TD   = 2;
    localparam int unsigned NL   = 2;
    localparam int unsigned MM   = 1;
    localparam int unsigned IDXW = $clog2(NL + 1);

    logic            CLK = 1'b0;
    logic            reset, start_stop, lap, recall, clear;
    logic [6:0]      disp_min, disp_sec, disp_cs;
    logic            running, recall_mode, laps_full, overflow;
    logic [IDXW-1:0] recall_idx, lap_count;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    // reference model state
    int run_cycles = 0;
    int t = 0;
    int laps[$];
    bit m_run = 0, m_rec = 0, m_ovf = 0;
    int m_idx = 0;

    lap_stopwatch #(.TICK_DIV(TD), .LAPS(NL), .MIN_MAX(MM), .IDXW(IDXW)) dut (
        .CLK(CLK), .reset(reset), .start_stop(start_stop), .lap(lap), .recall(recall),
        .clear(clear), .disp_min(disp_min), .disp_sec(disp_sec), .disp_cs(disp_cs),
        .running(running), .recall_mode(recall_mode), .recall_idx(recall_idx),
        .lap_count(lap_count), .laps_full(laps_full), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge CLK) begin
        int old_t;
        if (reset) begin
            run_cycles = 0; t = 0; laps.delete();
            m_run = 0; m_rec = 0; m_ovf = 0; m_idx = 0;
        end else if (clear && !m_run) begin
            run_cycles = 0; t = 0; laps.delete();
            m_run = 0; m_rec = 0; m_ovf = 0; m_idx = 0;
        end else if (m_run) begin
            if (lap && laps.size() < int'(NL)) laps.push_back(t);
            old_t = t;
            run_cycles++;
            t = run_cycles / int'(TD);
            if (t != old_t && (t % (6000 * int'(MM + 1))) == 0) m_ovf = 1;
            if (start_stop) m_run = 0;
        end else if (m_rec) begin
            if (start_stop) begin
                m_rec = 0; m_idx = 0;
            end else if (recall) begin
                if (m_idx < laps.size() - 1) m_idx++;
                else begin
                    m_rec = 0; m_idx = 0;
                end
            end
        end else begin
            if (start_stop) m_run = 1;
            else if (recall && laps.size() > 0) begin
                m_rec = 1; m_idx = 0;
            end
        end
    end

    always @(negedge CLK) begin
        int v;
        if (chk_en) begin
            v = m_rec ? laps[m_idx] : t;
            chk("disp_min", int'(disp_min), (v / 6000) % int'(MM + 1));
            chk("disp_sec", int'(disp_sec), (v / 100) % 60);
            chk("disp_cs", int'(disp_cs), v % 100);
            chk("running", int'(running), int'(m_run));
            chk("recall_mode", int'(recall_mode), int'(m_rec));
            chk("recall_idx", int'(recall_idx), m_idx);
            chk("lap_count", int'(lap_count), laps.size());
            chk("laps_full", int'(laps_full), int'(laps.size() == int'(NL)));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic pulse(input bit ss, input bit lp, input bit rc, input bit cl);
        start_stop = ss; lap = lp; recall = rc; clear = cl;
        cyc(1);
        start_stop = 0; lap = 0; recall = 0; clear = 0;
    endtask

    task automatic wait_cs(input int v);
        int k = 0;
        while (int'(disp_cs) != v && k < 400) begin
            cyc(1);
            k++;
        end
        if (int'(disp_cs) != v) chk("wait_cs_timeout", int'(disp_cs), v);
    endtask

    initial begin
        int k;
        reset = 1; start_stop = 0; lap = 0; recall = 0; clear = 0;
        cyc(2);
        reset = 0;
        chk_en = 1;
        chk("rst_cs", int'(disp_cs), 0);
        chk("rst_lap_count", int'(lap_count), 0);
        chk("rst_running", int'(running), 0);

        // 200 run cycles at TICK_DIV=2 -> exactly one second
        pulse(1, 0, 0, 0);
        cyc(200);
        chk("lit_cs_1s", int'(disp_cs), 0);
        chk("lit_sec_1s", int'(disp_sec), 1);
        chk("lit_min_1s", int'(disp_min), 0);
        chk("lit_running_1s", int'(running), 1);

        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        chk("lit_clear_sec", int'(disp_sec), 0);
        pulse(0, 0, 1, 0);
        chk("lit_recall_empty", int'(recall_mode), 0);

        // lap capture up to capacity, clear ignored while running
        pulse(1, 0, 0, 0);
        wait_cs(5);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        chk("lit_clear_in_run", int'(running), 1);
        wait_cs(9);
        pulse(0, 1, 0, 0);
        wait_cs(20);
        pulse(0, 1, 0, 0);
        chk("lit_lap_count", int'(lap_count), 2);
        chk("lit_laps_full", int'(laps_full), 1);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("lit_recall0_cs", int'(disp_cs), 5);
        chk("lit_recall0_mode", int'(recall_mode), 1);
        pulse(0, 0, 1, 0);
        chk("lit_recall1_cs", int'(disp_cs), 9);
        chk("lit_recall1_idx", int'(recall_idx), 1);
        pulse(0, 0, 1, 0);
        chk("lit_recall_exit", int'(recall_mode), 0);

        // lap + start_stop together
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        wait_cs(37);
        pulse(1, 1, 0, 0);
        chk("lit_lapstop_run", int'(running), 0);
        chk("lit_lapstop_cs", int'(disp_cs), 37);
        pulse(0, 0, 1, 0);
        chk("lit_lapstop_slot", int'(disp_cs), 37);

        // reset while in recall
        reset = 1;
        cyc(1);
        reset = 0;
        chk("lit_rst_rec_mode", int'(recall_mode), 0);
        chk("lit_rst_rec_laps", int'(lap_count), 0);
        chk("lit_rst_rec_cs", int'(disp_cs), 0);

        // clear + recall together in recall
        pulse(1, 0, 0, 0);
        cyc(30);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("lit_in_recall", int'(recall_mode), 1);
        pulse(0, 0, 1, 1);
        chk("lit_clr_rec_mode", int'(recall_mode), 0);
        chk("lit_clr_rec_laps", int'(lap_count), 0);
        chk("lit_clr_rec_cs", int'(disp_cs), 0);

        // minute wrap at MIN_MAX=1 sets overflow
        pulse(1, 0, 0, 0);
        k = 0;
        while (!overflow && k < 30000) begin
            cyc(1);
            k++;
        end
        chk("lit_ovf_set", int'(overflow), 1);
        chk("lit_ovf_min", int'(disp_min), 0);
        chk("lit_ovf_sec", int'(disp_sec), 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        chk("lit_ovf_clr", int'(overflow), 0);

        // random pulses
        for (int i = 0; i < 6000; i++) begin
            start_stop = ($urandom_range(0, 99) < 4);
            lap        = ($urandom_range(0, 99) < 8);
            recall     = ($urandom_range(0, 99) < 8);
            clear      = ($urandom_range(0, 99) < 1);
            reset      = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        start_stop = 0; lap = 0; recall = 0; clear = 0; reset = 0;
        cyc(2);
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
